normalizer_divider_seq: RTL
===========================

NORMALIZER_DIVIDER_SEQ -- requirements
Module: normalizer_divider_seq

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width, two's complement, range 8..64.
REQ-002 Parameter FRAC, default 16: fractional bits appended to the dividend, range 0..WIDTH-1.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in1  input  WIDTH  signed dividend.
REQ-006 in2  input  WIDTH  signed divisor.
REQ-007 in_valid  input  1  operands valid.
REQ-008 in_ready  output  1  block can accept operands.
REQ-009 out  output  WIDTH  signed quotient, (in1 << FRAC) / in2.
REQ-010 out_valid  output  1  result valid; held until accepted.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 dz  output  1  divide-by-zero flag; valid with out_valid.
REQ-013 ovf  output  1  saturation flag; valid with out_valid.

Function
REQ-014 The block SHALL use states IDLE, CALC, FIX and DONE, with a single operation in flight at a time.
REQ-015 in_ready SHALL be 1 only in IDLE; an accept occurs on an edge with in_valid=1 and in_ready=1.
REQ-016 On accept, the block SHALL register sign = in1[MSB]^in2[MSB] and the unsigned WIDTH-bit magnitudes of both operands; the magnitude of -2^(WIDTH-1) is exact.
REQ-017 On accept with in2=0, the block SHALL go to FIX (skipping CALC) with dz set; otherwise it SHALL go to CALC with the counter cleared.
REQ-018 CALC SHALL perform restoring division, one quotient bit per cycle, on N=WIDTH+FRAC iterations, with dividend = magnitude(in1) concatenated with FRAC zero bits.
REQ-019 FIX (one cycle) SHALL saturate when dz=1 or the magnitude quotient exceeds the limit: 2^(WIDTH-1)-1 if sign=0, 2^(WIDTH-1) if sign=1.
REQ-020 FIX SHALL apply the sign as follows: sign=0 saturates to 0x7FF..F; sign=1 saturates to 0x800..0; otherwise the result is negated when sign=1; ovf=1 on any saturation other than dz.
REQ-021 dz=1 SHALL use sign of in1 only: in1>=0 gives 0x7FF..F, in1<0 gives 0x800..0; ovf=0.
REQ-022 out, dz and ovf SHALL be registered on entry to DONE and held stable while out_valid=1.
REQ-023 Latency: accept at edge k gives out_valid=1 from edge k+N+2 (k+2 for dz).
REQ-024 In DONE with out_ready=1, the block SHALL go to IDLE on that edge; out_valid falls and in_ready rises on the same edge; no new accept occurs in that cycle.
REQ-025 out_ready SHALL be ignored when out_valid=0; in_valid SHALL be ignored outside IDLE.
REQ-026 Quotient 0, e.g. |in1|<<FRAC < |in2|, SHALL output 0 with ovf=0 regardless of sign.

Reset
REQ-027 rst=1 SHALL force IDLE, clear the counter and datapath, and set out=0, out_valid=0, dz=0, ovf=0, in_ready=1 on the next edge.
REQ-028 rst asserted mid-CALC or in DONE SHALL abort the operation with no result produced; rst has priority over every handshake.

Configuration
REQ-029 Macro NORMALIZER_DIV_ROUND_EN defined: CALC SHALL run N+1 iterations, and the extra LSB SHALL round the magnitude half away from zero before FIX; latency becomes k+N+3.
REQ-030 Macro NORMALIZER_DIV_ROUND_EN undefined: the result SHALL truncate toward zero with the latency of REQ-023.

Verification (WIDTH=32, FRAC=16)
REQ-031 in1=0x00030000, in2=0x00020000 -> out=0x00018000, dz=0, ovf=0, out_valid at accept+50.
REQ-032 in1=0xFFFFFFFA, in2=0x00000003 -> out=0xFFFE0000; in1=5, in2=0 -> out=0x7FFFFFFF, dz=1 at accept+2.
REQ-033 in1=0x40000000, in2=1 -> out=0x7FFFFFFF, ovf=1; in1=0xC0000000, in2=1 -> out=0x80000000, ovf=1.
REQ-034 in1=2, in2=3 -> out=0x0000AAAA without the macro; out=0x0000AAAB with NORMALIZER_DIV_ROUND_EN, at accept+51.
REQ-035 out_ready held 0 for 10 cycles after out_valid -> out, flags stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next edge.
REQ-036 rst pulsed at accept+20 -> out_valid never rises for that operation; the next operation 6/3 (Q16) returns 0x00020000.

Source files
------------

// File: rtl/normalizer_divider_seq.sv
// normalizer_divider_seq
//   Sequential signed fixed-point divider: out = (in1 << FRAC) / in2.
//   Magnitudes are divided by restoring division, one quotient bit per
//   cycle. The sign is applied and the result saturated in a single
//   FIX cycle. One operation is in flight at a time.
//
//   Parameters
//     WIDTH  operand/result width (8..64), two's complement
//     FRAC   fractional bits appended to the dividend (0..WIDTH-1)
//
//   Ports
//     clk        rising-edge clock
//     rst        synchronous active-high reset, priority over handshakes
//     in1/in2    signed dividend / divisor
//     in_valid   operands valid; accepted when in_ready=1
//     in_ready   high only while idle
//     out        signed quotient, truncated toward zero
//     out_valid  result valid; held until out_ready
//     out_ready  consumer accepts the result
//     dz         divide-by-zero flag, valid with out_valid
//     ovf        saturation flag (not set for divide by zero)
//
//   Optional feature
//     NORMALIZER_DIV_ROUND_EN  when defined, one extra quotient bit is
//     produced. It rounds the magnitude half away from zero, which adds
//     one cycle of latency.
module normalizer_divider_seq #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             dz,
    output logic             ovf
);

    localparam int N = WIDTH + FRAC;
`ifdef NORMALIZER_DIV_ROUND_EN
    localparam int ITER = N + 1;
`else
    localparam int ITER = N;
`endif
    localparam int CW = $clog2(ITER + 1);

    // Magnitude limits, widened to the N+1 bit quotient magnitude
    localparam logic [N:0] LIM_POS = {{(FRAC + 2){1'b0}}, {(WIDTH - 1){1'b1}}};
    localparam logic [N:0] LIM_NEG = LIM_POS + 1'b1;
    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH - 1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH - 1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_sign;
    logic             r_dz_pend;
    logic [WIDTH-1:0] r_mag2;
    logic [WIDTH-1:0] r_rem;
    logic [ITER-1:0]  r_dvd;
    logic [ITER-1:0]  r_quo;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_out;
    logic             r_dz;
    logic             r_ovf;

    logic [WIDTH-1:0] w_mag1;
    logic [WIDTH-1:0] w_mag2;
    logic [WIDTH:0]   w_trial;
    logic             w_ge;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [N:0]       w_qmag;
    logic [WIDTH:0]   w_fix;

    // Collapse the raw quotient into an N+1 bit magnitude
    function automatic logic [N:0] round_mag(input logic [ITER-1:0] q);
`ifdef NORMALIZER_DIV_ROUND_EN
        // Extra LSB is the half bit: add it to round half away from zero
        return {1'b0, q[ITER-1:1]} + {{N{1'b0}}, q[0]};
`else
        return {1'b0, q};
`endif
    endfunction

    // Returns {ovf, result}. With a zero divisor, sign equals in1's sign
    // because the divisor's MSB is 0.
    function automatic logic [WIDTH:0] fix_result(input logic [N:0] qmag,
                                                  input logic       sign,
                                                  input logic       dzero);
        logic sat;
        sat = dzero | (qmag > (sign ? LIM_NEG : LIM_POS));
        if (sat)
            return {~dzero, (sign ? SAT_MIN : SAT_MAX)};
        else
            return {1'b0, (sign ? -qmag[WIDTH-1:0] : qmag[WIDTH-1:0])};
    endfunction

    // Unsigned magnitudes; -2^(WIDTH-1) maps exactly onto 2^(WIDTH-1)
    assign w_mag1 = in1[WIDTH-1] ? -in1 : in1;
    assign w_mag2 = in2[WIDTH-1] ? -in2 : in2;

    // Restoring step: the partial remainder is always < divisor, so the
    // subtraction result fits in WIDTH bits
    assign w_trial   = {r_rem, r_dvd[ITER-1]};
    assign w_ge      = w_trial >= {1'b0, r_mag2};
    assign w_diff    = w_trial[WIDTH-1:0] - r_mag2;
    assign w_rem_nxt = w_ge ? w_diff : w_trial[WIDTH-1:0];

    assign w_qmag = round_mag(r_quo);
    assign w_fix  = fix_result(w_qmag, r_sign, r_dz_pend);

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_next = (in2 == '0) ? FIX : CALC;
            CALC:    if (r_cnt == CW'(ITER - 1)) w_next = FIX;
            FIX:     w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sign    <= 1'b0;
            r_dz_pend <= 1'b0;
            r_mag2    <= '0;
            r_rem     <= '0;
            r_dvd     <= '0;
            r_quo     <= '0;
            r_cnt     <= '0;
            r_out     <= '0;
            r_dz      <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_sign    <= in1[WIDTH-1] ^ in2[WIDTH-1];
                        r_dz_pend <= (in2 == '0);
                        r_mag2    <= w_mag2;
                        r_dvd     <= ITER'(w_mag1) << (ITER - WIDTH);
                        r_rem     <= '0;
                        r_quo     <= '0;
                        r_cnt     <= '0;
                    end
                end
                CALC: begin
                    r_rem <= w_rem_nxt;
                    r_dvd <= r_dvd << 1;
                    r_quo <= {r_quo[ITER-2:0], w_ge};
                    r_cnt <= r_cnt + CW'(1);
                end
                FIX: begin
                    r_out <= w_fix[WIDTH-1:0];
                    r_ovf <= w_fix[WIDTH];
                    r_dz  <= r_dz_pend;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign out       = r_out;
    assign dz        = r_dz;
    assign ovf       = r_ovf;

endmodule
